sseg_scan_driver: RTL

- Downstream consumer of the stopwatch counter's four BCD digit outputs d3..d0.
- Time-multiplexes the four digits onto one common-anode 7-segment bus with active-low digit enables.
- Adds frame-synchronous input snapshotting (tear-free), anti-ghosting guard time, optional leading-zero blanking and per-digit decimal points.

---
 rtl/sseg_pkg.sv | 20 ++
 rtl/hex_to_sseg.sv | 11 +
 rtl/sseg_scan_driver.sv | 108 ++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for seven-segment display blocks: active-low segment patterns,
// idle bus values and the layout of the frame snapshot buffer.
package sseg_pkg;

    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns indexed by hex value; entry 0 sits at the right.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [3:0][3:0] digits;
        logic [3:0]      dp;
        logic            blankEn;
    } snap_t;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex digit to active-low seven-segment decoder, shared by display blocks.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode scan driver with per-frame input snapshot, guard time
// between digits, optional leading-zero blanking and per-digit decimal points.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int N     = 18,
    parameter int GUARD = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] dp_in,
    input  logic       blank_en,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_ONE = N'(1);

    logic [N-1:0] cnt_q, cnt_d;
    snap_t        snap_q, snap_d;
    logic [3:0]   an_q, an_d;
    logic [7:0]   sseg_q, sseg_d;
    logic         frameTick_q, frameTick_d;

    logic         wrap;
    logic         inGuard;
    logic         digitOn;
    logic [1:0]   slot;
    logic [3:0]   blanked;
    logic [3:0]   curDigit;
    logic [6:0]   curSeg;

    assign wrap     = (cnt_q == CNT_MAX);
    assign slot     = cnt_q[N-1:N-2];
    assign curDigit = snap_q.digits[slot];

    generate
        if (GUARD == 0) begin : g_noGuard
            assign inGuard = 1'b0;
        end else begin : g_guard
            localparam logic [N-3:0] GUARD_W = (N-2)'(GUARD);
            assign inGuard = (cnt_q[N-3:0] < GUARD_W);
        end
    endgenerate

    hex_to_sseg u_decode (
        .hex_i (curDigit),
        .seg_o (curSeg)
    );

    // Inputs are only sampled at the frame wrap so a digit can never tear mid-frame.
    always_comb begin
        cnt_d       = cnt_q + CNT_ONE;
        frameTick_d = wrap;
        snap_d      = snap_q;
        if (wrap) begin
            snap_d.digits  = {d3, d2, d1, d0};
            snap_d.dp      = dp_in;
            snap_d.blankEn = blank_en;
        end
    end

    // A digit is a leading zero only if it and every more-significant digit are zero.
    always_comb begin
        blanked    = 4'b0000;
        blanked[3] = snap_q.blankEn && (snap_q.digits[3] == 4'd0);
        blanked[2] = blanked[3] && (snap_q.digits[2] == 4'd0);
        blanked[1] = blanked[2] && (snap_q.digits[1] == 4'd0);
    end

    assign digitOn = !inGuard && !blanked[slot];

    always_comb begin
        an_d   = AN_OFF;
        sseg_d = SEG_BLANK;
        if (digitOn) begin
            an_d[slot] = 1'b0;
            sseg_d     = {~snap_q.dp[slot], curSeg};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            snap_q      <= '0;
            an_q        <= AN_OFF;
            sseg_q      <= SEG_BLANK;
            frameTick_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            sseg_q      <= sseg_d;
            frameTick_q <= frameTick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = frameTick_q;

endmodule
